// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with frame-aligned value updates.
// Define DISPLAY_SCAN_LZB_EN to enable leading-zero blanking.
module display_scan_ctrl #(
   parameter int unsigned PRESCALE  = 48,
   parameter int unsigned BLANK_CYC = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [15:0] in_bcd,
   input  logic        load,
   output logic        busy,
   output logic [3:0]  out_bcd,
   output logic [3:0]  digit_sel,
   output logic        blank,
   output logic        frame_start
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHOW  = 2'd1;
   localparam logic [1:0] S_BLANK = 2'd2;

   localparam logic [7:0] SHOW_LAST  = 8'(PRESCALE - 1);
   localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [15:0]      active_q, active_d;
   logic [15:0]      pending_q, pending_d;
   logic             busy_q, busy_d;
   logic             boundary;
   logic             suppress;
   logic             show_on;
   logic [3:0][3:0]  digits;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (!en) begin
         state_d = S_IDLE;
         idx_d   = 2'd0;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d  = S_SHOW;
               idx_d    = 2'd0;
               cnt_d    = 8'd0;
               boundary = 1'b1;
            end
            S_SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d  = S_SHOW;
                  cnt_d    = 8'd0;
                  idx_d    = idx_q + 2'd1;
                  boundary = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = 8'd0;
            end
         endcase
      end
   end

   // Active only changes at a frame boundary so a frame never mixes two values;
   // a load coinciding with the boundary bypasses pending.
   always_comb begin
      active_d  = active_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      if (boundary) begin
         if (load) begin
            active_d  = in_bcd;
            pending_d = in_bcd;
         end else if (busy_q) begin
            active_d = pending_q;
         end
         busy_d = 1'b0;
      end else if (load) begin
         pending_d = in_bcd;
         busy_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         idx_q     <= 2'd0;
         cnt_q     <= 8'd0;
         active_q  <= 16'd0;
         pending_q <= 16'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
      end
   end

   assign digits = active_q;

`ifdef DISPLAY_SCAN_LZB_EN
   always_comb begin
      suppress = 1'b0;
      case (idx_q)
         2'd3: suppress = (digits[3] == 4'd0);
         2'd2: suppress = (digits[3] == 4'd0) && (digits[2] == 4'd0);
         2'd1: suppress = (active_q[15:4] == 12'd0);
         default: suppress = 1'b0;
      endcase
   end
`else
   always_comb begin
      suppress = 1'b0;
   end
`endif

   // out_bcd follows idx, which is frozen through BLANK, so it holds there.
   assign show_on     = (state_q == S_SHOW) && !suppress;
   assign digit_sel   = show_on ? ~(4'b0001 << idx_q) : 4'b1111;
   assign blank       = !show_on;
   assign out_bcd     = digits[idx_q];
   assign frame_start = (state_q == S_SHOW) && (idx_q == 2'd0) && (cnt_q == 8'd0);
   assign busy        = busy_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (PRESCALE=4, BLANK_CYC=1); expected frames
// are queued when a value is loaded and checked cycle by cycle when the frame runs.
module tb_display_scan_ctrl;

   localparam int P = 4;
   localparam int B = 1;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [15:0] in_bcd;
   logic        load;
   logic        busy;
   logic [3:0]  out_bcd;
   logic [3:0]  digit_sel;
   logic        blank;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];

   display_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
      .clk(clk), .resetn(resetn), .en(en), .in_bcd(in_bcd), .load(load),
      .busy(busy), .out_bcd(out_bcd), .digit_sel(digit_sel), .blank(blank),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic lzb_hide(input logic [15:0] v, input int d);
`ifdef DISPLAY_SCAN_LZB_EN
      return (d != 0) && ((v >> (4 * d)) == 16'd0);
`else
      return 1'b0;
`endif
   endfunction

   // Wait for frame_start, then check one full frame against the next queued value.
   task automatic check_frame(input string tag);
      logic [15:0] v;
      logic [3:0]  sel;
      logic        hide;
      int          n;
      v = sb.pop_front();
      n = 0;
      while (frame_start !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_fs_found"}, 16'(frame_start), 16'd1);
      for (int d = 0; d < 4; d++) begin
         hide = lzb_hide(v, d);
         sel  = ~(4'b0001 << d);
         for (int c = 0; c < P; c++) begin
            chk({tag, "_dsel"}, 16'(digit_sel), hide ? 16'hF : 16'(sel));
            chk({tag, "_blank"}, 16'(blank), 16'(hide));
            chk({tag, "_fs"}, 16'(frame_start), 16'((d == 0) && (c == 0)));
            if (!hide) chk({tag, "_out"}, 16'(out_bcd), 16'(v[d*4 +: 4]));
            tick();
         end
         for (int c = 0; c < B; c++) begin
            chk({tag, "_gap_dsel"}, 16'(digit_sel), 16'hF);
            chk({tag, "_gap_blank"}, 16'(blank), 16'd1);
            tick();
         end
      end
      chk({tag, "_period"}, 16'(frame_start), 16'd1);
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; load = 1'b0; in_bcd = 16'h0;
      ticks(2);
      chk("rst_dsel", 16'(digit_sel), 16'hF);
      chk("rst_blank", 16'(blank), 16'd1);
      chk("rst_out", 16'(out_bcd), 16'd0);
      chk("rst_fs", 16'(frame_start), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);

      // Basic scan of 1234, loaded while idle
      resetn = 1'b1;
      load = 1'b1; in_bcd = 16'h1234;
      tick();
      load = 1'b0;
      chk("idle_busy", 16'(busy), 16'd1);
      en = 1'b1;
      tick();
      chk("first_busy", 16'(busy), 16'd0);
      sb.push_back(16'h1234);
      check_frame("f1234");

      // Load mid-frame: current frame keeps old digits
      ticks(5);
      load = 1'b1; in_bcd = 16'h5678;
      tick();
      load = 1'b0;
      chk("mid_busy", 16'(busy), 16'd1);
      ticks(4);
      chk("mid_d2_out", 16'(out_bcd), 16'h2);
      chk("mid_d2_sel", 16'(digit_sel), 16'hB);
      ticks(5);
      chk("mid_d3_out", 16'(out_bcd), 16'h1);
      chk("mid_d3_sel", 16'(digit_sel), 16'h7);
      sb.push_back(16'h5678);
      check_frame("f5678");
      chk("after_busy", 16'(busy), 16'd0);

      // Last load wins
      load = 1'b1; in_bcd = 16'hAAAA;
      tick();
      in_bcd = 16'h0042;
      tick();
      load = 1'b0;
      chk("lw_busy", 16'(busy), 16'd1);
      sb.push_back(16'h0042);
      check_frame("f0042");

      // Load on the boundary cycle goes straight to the display
      ticks(19);
      load = 1'b1; in_bcd = 16'h9876;
      tick();
      load = 1'b0;
      chk("bnd_busy", 16'(busy), 16'd0);
      sb.push_back(16'h9876);
      check_frame("f9876");

      // Leading-zero cases
      load = 1'b1; in_bcd = 16'h0040;
      tick();
      load = 1'b0;
      sb.push_back(16'h0040);
      check_frame("f0040");
      load = 1'b1; in_bcd = 16'h0000;
      tick();
      load = 1'b0;
      sb.push_back(16'h0000);
      check_frame("f0000");

      // Drop en during digit 2, then re-enable
      load = 1'b1; in_bcd = 16'h1234;
      tick();
      load = 1'b0;
      sb.push_back(16'h1234);
      check_frame("f1234b");
      ticks(11);
      chk("pre_off_sel", 16'(digit_sel), 16'hB);
      en = 1'b0;
      tick();
      chk("off_dsel", 16'(digit_sel), 16'hF);
      chk("off_blank", 16'(blank), 16'd1);
      chk("off_fs", 16'(frame_start), 16'd0);
      ticks(3);
      chk("off_dsel2", 16'(digit_sel), 16'hF);
      en = 1'b1;
      tick();
      chk("reen_fs", 16'(frame_start), 16'd1);
      chk("reen_dsel", 16'(digit_sel), 16'hE);
      sb.push_back(16'h1234);
      check_frame("f_reen");

      // Reset mid-frame with a pending value, overriding load and en
      ticks(3);
      load = 1'b1; in_bcd = 16'h5555;
      tick();
      load = 1'b0;
      chk("prerst_busy", 16'(busy), 16'd1);
      resetn = 1'b0; load = 1'b1; in_bcd = 16'h7777;
      tick();
      resetn = 1'b1; load = 1'b0;
      chk("mrst_dsel", 16'(digit_sel), 16'hF);
      chk("mrst_blank", 16'(blank), 16'd1);
      chk("mrst_out", 16'(out_bcd), 16'd0);
      chk("mrst_fs", 16'(frame_start), 16'd0);
      chk("mrst_busy", 16'(busy), 16'd0);
      tick();
      chk("postrst_fs", 16'(frame_start), 16'd1);
      chk("postrst_out", 16'(out_bcd), 16'd0);
      sb.push_back(16'h0000);
      check_frame("f_postrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
